// File: rtl/bpsk_tx_scheduler_if.sv
// Receiver-to-modulator bundle for bpsk_tx_scheduler: frame ingress, burst
// outputs and status counters. The scheduler uses slave; the driver uses master.
interface bpsk_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_done;
    logic [DATA_WIDTH:0]   rx_data;
    logic                  tx_enable;
    logic                  mod_en;
    logic [DATA_WIDTH:0]   mod_data;
    logic                  mod_bit;
    logic                  bit_strobe;
    logic                  busy;
    logic                  fifo_full;
    logic                  err;
    logic [7:0]            err_cnt;
    logic [7:0]            ovf_cnt;

    modport slave (
        input  rx_done, rx_data, tx_enable,
        output mod_en, mod_data, mod_bit, bit_strobe, busy, fifo_full,
               err, err_cnt, ovf_cnt
    );

    modport master (
        output rx_done, rx_data, tx_enable,
        input  mod_en, mod_data, mod_bit, bit_strobe, busy, fifo_full,
               err, err_cnt, ovf_cnt
    );
endinterface

// File: rtl/bpsk_tx_scheduler.sv
// Parity-checks received frames, queues good ones, and plays them out to the
// BPSK modulator as LSB-first bursts separated by a fixed idle gap.
module bpsk_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SYM_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               arst,
    bpsk_tx_scheduler_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int SW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic [DATA_WIDTH:0]   mod_data;
    logic [DATA_WIDTH-1:0] payload;
    logic [BW-1:0]         bit_idx;
    logic [SW-1:0]         sym_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  err_q;
    logic [7:0]            err_cnt, ovf_cnt;

    logic good, bad, full, empty, pop, push, drop;
    logic sym_last, bit_last, gap_last;

    assign good  = bus.rx_done & ~(^bus.rx_data);
    assign bad   = bus.rx_done &  (^bus.rx_data);
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == LOAD);
    // A full queue still accepts a frame when LOAD frees a slot on the same edge.
    assign push  = good & (~full | pop);
    assign drop  = good & full & ~pop;

    assign sym_last = (sym_cnt == SW'(SYM_CYCLES - 1));
    assign bit_last = (bit_idx == BW'(DATA_WIDTH - 1));
    assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            err_q   <= 1'b0;
            err_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            err_q <= bad;
            if (bad && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
            if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (!empty && bus.tx_enable) state_nx = LOAD;
            LOAD: state_nx = SEND;
            SEND: if (sym_last && bit_last) state_nx = GAP;
            GAP:  if (gap_last) state_nx = (!empty && bus.tx_enable) ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // mod_data is left alone after a burst so the last frame stays visible.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            mod_data <= '0;
            bit_idx  <= '0;
            sym_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    mod_data <= mem[rd_ptr];
                    bit_idx  <= '0;
                    sym_cnt  <= '0;
                    gap_cnt  <= '0;
                end
                SEND: begin
                    if (sym_last) begin
                        sym_cnt <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
                GAP: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign payload        = mod_data[DATA_WIDTH-1:0];
    assign bus.mod_en     = (state == SEND);
    assign bus.mod_data   = mod_data;
    assign bus.mod_bit    = (state == SEND) & payload[bit_idx];
    assign bus.bit_strobe = (state == SEND) & (sym_cnt == '0);
    assign bus.busy       = (state != IDLE);
    assign bus.fifo_full  = full;
    assign bus.err        = err_q;
    assign bus.err_cnt    = err_cnt;
    assign bus.ovf_cnt    = ovf_cnt;
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Directed bench for bpsk_tx_scheduler: parity, queueing, overflow, burst
// timing, reset mid-burst and tx_enable gating, with hand-computed expectations.
module tb_bpsk_tx_scheduler;
    localparam int DW = 8;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   w;

    bpsk_tx_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    bpsk_tx_scheduler #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(4),
        .SYM_CYCLES(4),
        .GAP_CYCLES(2)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [8:0] d);
        bus.rx_done = 1'b1;
        bus.rx_data = d;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.busy || bus.mod_en) act++;
            @(negedge clk);
        end
        chk(tag, act, 0);
    endtask

    // Waits (bounded) for a burst, then checks length, frame, bit pattern and strobes.
    task automatic chk_burst(input string tag, input logic [8:0] exp, input int drop_at,
                             output int waited);
        int         wt = 0;
        int         len = 0;
        int         strobes = 0;
        int         bad_data = 0;
        int         bad_bit = 0;
        logic [7:0] bits = '0;
        while (!bus.mod_en && wt < 40) begin
            @(negedge clk);
            wt++;
        end
        waited = wt;
        chk({tag, "_start"}, 32'(bus.mod_en), 1);
        while (bus.mod_en && len < 64) begin
            if (bus.bit_strobe) begin
                if (strobes < 8) bits[strobes] = bus.mod_bit;
                strobes++;
            end
            if (bus.mod_data !== exp) bad_data++;
            if (len < 32 && bus.mod_bit !== exp[len/4]) bad_bit++;
            if (len == drop_at) bus.tx_enable = 1'b0;
            len++;
            @(negedge clk);
        end
        chk({tag, "_len"}, len, 32);
        chk({tag, "_strobes"}, strobes, 8);
        chk({tag, "_bits"}, 32'(bits), 32'(exp[7:0]));
        chk({tag, "_data"}, bad_data, 0);
        chk({tag, "_bitcyc"}, bad_bit, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_done   = 1'b0;
        bus.rx_data   = '0;
        bus.tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mod_en",  32'(bus.mod_en), 0);
        chk("rst_busy",    32'(bus.busy), 0);
        chk("rst_full",    32'(bus.fifo_full), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        chk("rst_ovf_cnt", 32'(bus.ovf_cnt), 0);
        chk("rst_data",    32'(bus.mod_data), 0);
        arst = 1'b1;
        @(negedge clk);

        // single good frame
        bus.tx_enable = 1'b1;
        strobe(9'h0A5);
        chk("t1_err", 32'(bus.err), 0);
        chk("t1_busy_n1", 32'(bus.busy), 0);
        chk_burst("t1", 9'h0A5, -1, w);
        chk("t1_lat", w, 2);
        chk("t1_bits_lit", 32'(bus.mod_data[7:0]), 32'h0A5);
        chk("t1_err_cnt", 32'(bus.err_cnt), 0);
        chk("t1_gap_busy", 32'(bus.busy), 1);
        repeat (2) @(negedge clk);
        chk("t1_idle", 32'(bus.busy), 0);

        // bad parity frame
        strobe(9'h1A5);
        chk("t2_err", 32'(bus.err), 1);
        chk("t2_err_cnt", 32'(bus.err_cnt), 1);
        @(negedge clk);
        chk("t2_err_pulse", 32'(bus.err), 0);
        idle_check("t2_idle", 8);
        chk("t2_full", 32'(bus.fifo_full), 0);

        // overflow with tx disabled, then drain four bursts
        bus.tx_enable = 1'b0;
        strobe(9'h101); strobe(9'h102); strobe(9'h003);
        strobe(9'h104); strobe(9'h005); strobe(9'h006);
        chk("t3_full", 32'(bus.fifo_full), 1);
        chk("t3_ovf", 32'(bus.ovf_cnt), 2);
        chk("t3_err_cnt", 32'(bus.err_cnt), 1);
        bus.tx_enable = 1'b1;
        chk_burst("t3a", 9'h101, -1, w); chk("t3a_lat", w, 2);
        chk_burst("t3b", 9'h102, -1, w); chk("t3b_gap", w, 3);
        chk_burst("t3c", 9'h003, -1, w); chk("t3c_gap", w, 3);
        chk_burst("t3d", 9'h104, -1, w); chk("t3d_gap", w, 3);
        repeat (2) @(negedge clk);
        idle_check("t3_tail", 12);

        // push into a full queue while LOAD pops
        bus.tx_enable = 1'b0;
        strobe(9'h011); strobe(9'h022); strobe(9'h033); strobe(9'h044);
        chk("t4_full", 32'(bus.fifo_full), 1);
        bus.tx_enable = 1'b1;
        @(negedge clk);
        chk("t4_load_busy", 32'(bus.busy), 1);
        chk("t4_load_en", 32'(bus.mod_en), 0);
        strobe(9'h055);
        chk("t4_still_full", 32'(bus.fifo_full), 1);
        chk("t4_ovf", 32'(bus.ovf_cnt), 2);
        chk_burst("t4a", 9'h011, -1, w); chk("t4a_lat", w, 0);
        chk_burst("t4b", 9'h022, -1, w); chk("t4b_gap", w, 3);
        chk_burst("t4c", 9'h033, -1, w); chk("t4c_gap", w, 3);
        chk_burst("t4d", 9'h044, -1, w); chk("t4d_gap", w, 3);
        chk_burst("t4e", 9'h055, -1, w); chk("t4e_gap", w, 3);
        repeat (2) @(negedge clk);
        chk("t4_idle", 32'(bus.busy), 0);

        // asynchronous reset mid-burst with frames queued
        bus.tx_enable = 1'b0;
        strobe(9'h066); strobe(9'h077); strobe(9'h088);
        bus.tx_enable = 1'b1;
        w = 0;
        while (!bus.mod_en && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("t5_start", 32'(bus.mod_en), 1);
        repeat (10) @(negedge clk);
        #2 arst = 1'b0;
        #1;
        chk("t5_rst_en",   32'(bus.mod_en), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_data", 32'(bus.mod_data), 0);
        chk("t5_rst_bit",  32'({bus.mod_bit, bus.bit_strobe, bus.err}), 0);
        chk("t5_rst_cnts", 32'({bus.err_cnt, bus.ovf_cnt}), 0);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b1;
        idle_check("t5_post", 20);
        chk("t5_cnts", 32'({bus.err_cnt, bus.ovf_cnt}), 0);
        chk("t5_full", 32'(bus.fifo_full), 0);

        // tx_enable dropped mid-burst, then resumed
        bus.tx_enable = 1'b0;
        strobe(9'h099); strobe(9'h0AA); strobe(9'h0BB);
        bus.tx_enable = 1'b1;
        chk_burst("t6a", 9'h099, 5, w); chk("t6a_lat", w, 2);
        repeat (2) @(negedge clk);
        idle_check("t6_hold", 10);
        bus.tx_enable = 1'b1;
        chk_burst("t6b", 9'h0AA, -1, w); chk("t6b_lat", w, 2);
        chk_burst("t6c", 9'h0BB, -1, w); chk("t6c_gap", w, 3);
        repeat (2) @(negedge clk);
        chk("t6_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
